lidar_ring_scheduler: RTL
=========================

Name: lidar_ring_scheduler

Overview:
- Shares the single ground-segmentation core among N_CH lidar ring (laser channel) streams.
- Grants the core to one ring for a whole packet (first point through the point flagged last), then switches using round-robin.
- Between rings, holds the core in reset so filter history never leaks from one ring to the next.
- Tags every in-flight point so each core result returns to its ring; counts ground points per ring.

Parameters:
- N_CH, 4, number of ring requesters (2..16).
- DATA_WIDTH, 16, width of z and r samples.
- PIPE_LAT, 3, fixed core latency: cycles from seg_valid high to matching seg_result_valid high (1..15).
- CLR_CYC, 2, cycles seg_rst_n is held low between rings (>=1).
- CNT_W, 12, width of the per-ring ground counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  N_CH  per-ring point valid.
- req_last  in  N_CH  per-ring last point of packet; qualified by valid.
- req_z  in  N_CH*DATA_WIDTH  signed z of ring i in bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_r  in  N_CH*DATA_WIDTH  unsigned range of ring i, same packing.
- req_ready  out  N_CH  per-ring ready; at most one bit high.
- seg_rst_n  out  1  active-low reset to the core.
- seg_valid  out  1  data_valid_in to the core.
- seg_z  out  DATA_WIDTH  raw_z_in to the core.
- seg_r  out  DATA_WIDTH  raw_r_in to the core.
- seg_result  in  1  core segmentation result; 1 = ground, 0 = obstacle.
- seg_result_valid  in  1  core result valid.
- res_valid  out  1  routed result valid.
- res_ground  out  1  routed result.
- res_ch  out  $clog2(N_CH)  ring owning the result.
- res_last  out  1  result is the last of its packet.
- ring_done  out  1  one-cycle pulse after the last result of a packet.
- ring_ch  out  $clog2(N_CH)  ring reported by ring_done.
- ring_ground_cnt  out  CNT_W  ground results in that packet; saturates at all-ones.
- err  out  1  sticky error: tag/result mismatch.

Behaviour:
- Reset values:
  - seg_rst_n = 0; all other outputs = 0.
  - Round-robin pointer = N_CH-1, so ring 0 has first priority.
  - State = CLEAR with the clear counter loaded to CLR_CYC.
- CLEAR:
  - seg_rst_n = 0 and all req_ready = 0.
  - Stays CLR_CYC cycles, then goes to ARB. seg_rst_n goes to 1 on entering ARB.
- ARB:
  - Chooses the first ring i with req_valid[i], searching from pointer+1 with wrap.
  - On a hit: grant <= i, pointer <= i, next state STREAM.
  - No requests: stays in ARB.
  - Decision takes 1 cycle; req_ready stays 0 during ARB.
- STREAM:
  - req_ready[grant] = 1 as a registered flag set on ARB exit; other ready bits 0.
  - A transfer is req_valid & req_ready of the granted ring.
  - On a transfer at cycle t, seg_valid/seg_z/seg_r are registered copies at t+1. seg_valid is 0 on non-transfer cycles.
  - A transfer with req_last clears req_ready in the same cycle it is sampled, so no second point is accepted. Next state DRAIN.
  - Gaps (valid low) inside a packet are allowed. The grant is held and nothing is sent to the core.
- Tag pipeline:
  - PIPE_LAT-deep shift register of {valid, ch, last}, shifted every cycle.
  - Stage 0 is loaded in the same cycle seg_valid is driven.
  - The output stage aligns with seg_result_valid.
- Result routing, one cycle after seg_result_valid:
  - Drives res_valid = 1, res_ground = seg_result, and res_ch/res_last from the tag.
  - If a tag is valid but seg_result_valid = 0, or the reverse: err <= 1 (sticky until rst) and no res_valid for that slot.
- Ground counter:
  - Adds 1 per routed ground result; saturates.
  - On the routed result with last = 1: ring_done = 1 and ring_ch = tag ch in the same cycle as res_valid. ring_ground_cnt = final count including this result. The counter then clears to 0.
- DRAIN:
  - Waits until the tag pipeline holds no valid entry.
  - Goes to CLEAR in the cycle after the last tagged result leaves.
  - Minimum cost between packets is PIPE_LAT + CLR_CYC + 1 (ARB) cycles.
- Simultaneous requests: strict round-robin, for example rings 0 and 2 pending gives 0, 2, 0, 2.
- Single active ring: re-granted after every CLEAR.
- Packet of one point (first point has last = 1): handled as above; count is 0 or 1.
- A lost last (seg_result_valid missing for the last tag): err = 1. ring_done still pulses with the count so far. DRAIN still exits.
- rst asserted mid-packet: immediate return to reset values. The in-flight tags, counter and the partial packet are discarded. The requester re-sends its packet.

Test Plan:
- Ring 1 only: 15 points z=10, r=10..150, last on the 15th; core model with PIPE_LAT=3 always returns 1 -> 15 res_valid with res_ch=1; one ring_done, ring_ground_cnt=15; seg_rst_n low exactly 2 cycles afterwards.
- Rings 0 and 2 both pending with 5-point packets -> grant order 0, 2, 0; no req_ready overlap; seg_valid never high while seg_rst_n=0.
- Ring 3: 10 points with z=200 returning 0, then 5 with z=10 returning 1 -> ring_ground_cnt=5, res_last only on the 15th result.
- CNT_W=3 with a 10-point all-ground packet -> ring_ground_cnt=7 (saturated).
- Core model drops the 4th result -> err=1 and stays 1; ring_done still pulses; the next packet is granted normally.
- rst pulsed on the 3rd point of a packet -> all outputs 0 during rst and seg_rst_n=0; after release, CLEAR for 2 cycles, then ring 0 has priority; no stale res_valid.

Source files
------------

// File: rtl/lidar_ring_scheduler.sv
// lidar_ring_scheduler: time-shares one ground-segmentation core among N_CH
// lidar ring streams. A ring owns the core for a whole packet. Between rings
// the core is held in reset so no filter history carries over. Results come
// back through a tag pipeline, are routed to their ring and counted.
module lidar_ring_scheduler #(
    parameter int N_CH       = 4,
    parameter int DATA_WIDTH = 16,
    parameter int PIPE_LAT   = 3,
    parameter int CLR_CYC    = 2,
    parameter int CNT_W      = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_CH-1:0]               req_valid,
    input  logic [N_CH-1:0]               req_last,
    input  logic [N_CH*DATA_WIDTH-1:0]    req_z,
    input  logic [N_CH*DATA_WIDTH-1:0]    req_r,
    output logic [N_CH-1:0]               req_ready,
    output logic                          seg_rst_n,
    output logic                          seg_valid,
    output logic [DATA_WIDTH-1:0]         seg_z,
    output logic [DATA_WIDTH-1:0]         seg_r,
    input  logic                          seg_result,
    input  logic                          seg_result_valid,
    output logic                          res_valid,
    output logic                          res_ground,
    output logic [$clog2(N_CH)-1:0]       res_ch,
    output logic                          res_last,
    output logic                          ring_done,
    output logic [$clog2(N_CH)-1:0]       ring_ch,
    output logic [CNT_W-1:0]              ring_ground_cnt,
    output logic                          err
);

    localparam int CH_W  = $clog2(N_CH);
    localparam int CLR_W = $clog2(CLR_CYC + 1);

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_ARB,
        ST_STREAM,
        ST_DRAIN
    } state_t;

    // Tag carried alongside each point while it is inside the core.
    typedef struct packed {
        logic            valid;
        logic [CH_W-1:0] ch;
        logic            last;
    } tag_t;

    state_t           state, state_nxt;
    logic [CLR_W-1:0] clr_cnt;
    logic [CH_W-1:0]  ptr;
    logic [CH_W-1:0]  grant;
    logic [N_CH-1:0]  ready_q;
    logic [CH_W-1:0]  cand;
    logic [CH_W-1:0]  arb_idx;
    logic             arb_hit;
    logic             xfer;
    logic             xfer_last;
    logic             core_busy;
    tag_t             tag_pipe [PIPE_LAT+1];
    tag_t             tag_out;
    logic [CNT_W-1:0] gnd_cnt;
    logic [CNT_W-1:0] cnt_next;

    assign req_ready = ready_q;
    assign xfer      = (state == ST_STREAM) && req_valid[grant] && ready_q[grant];
    assign xfer_last = xfer && req_last[grant];
    assign tag_out   = tag_pipe[PIPE_LAT];

    // Round-robin search: first requesting ring after the pointer, with wrap.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, otherwise a latch is inferred.
        arb_hit = 1'b0;
        arb_idx = '0;
        cand    = '0;
        for (int k = 1; k <= N_CH; k++) begin
            cand = CH_W'((int'(ptr) + k) % N_CH);
            if (!arb_hit && req_valid[cand]) begin
                arb_hit = 1'b1;
                arb_idx = cand;
            end
        end
    end

    // Points still travelling toward the output stage keep DRAIN waiting.
    always_comb begin
        core_busy = 1'b0;
        for (int k = 0; k < PIPE_LAT; k++) begin
            core_busy = core_busy | tag_pipe[k].valid;
        end
    end

    // Next-state logic for the clear/arbitrate/stream/drain sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR:  if (clr_cnt == CLR_W'(1)) state_nxt = ST_ARB;
            ST_ARB:    if (arb_hit) state_nxt = ST_STREAM;
            ST_STREAM: if (xfer_last) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (!core_busy) state_nxt = ST_CLEAR;
            default:   state_nxt = ST_CLEAR;
        endcase
    end

    // Control registers: state, clear timer, grant, pointer and ready flag.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state     <= ST_CLEAR;
            clr_cnt   <= CLR_W'(CLR_CYC);
            ptr       <= CH_W'(N_CH - 1);
            grant     <= '0;
            ready_q   <= '0;
            seg_rst_n <= 1'b0;
        end else begin
            state     <= state_nxt;
            seg_rst_n <= (state_nxt != ST_CLEAR);
            if (state != ST_CLEAR && state_nxt == ST_CLEAR) begin
                clr_cnt <= CLR_W'(CLR_CYC);
            end else if (state == ST_CLEAR) begin
                clr_cnt <= clr_cnt - CLR_W'(1);
            end
            if (state == ST_ARB && arb_hit) begin
                grant   <= arb_idx;
                ptr     <= arb_idx;
                ready_q <= N_CH'(1) << arb_idx;
            end else if (xfer_last) begin
                // Drop ready at the last point so a second one is never taken.
                ready_q <= '0;
            end
        end
    end

    // Registered copy of the accepted point toward the core.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_valid <= 1'b0;
            seg_z     <= '0;
            seg_r     <= '0;
        end else begin
            seg_valid <= xfer;
            if (xfer) begin
                seg_z <= req_z[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
                seg_r <= req_r[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Tag shift register: stage 0 moves with seg_valid, last stage meets the result.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the tag stages are reset because their valid bits drive err and DRAIN; stale tags must not survive rst.
        if (rst) begin
            for (int k = 0; k <= PIPE_LAT; k++) tag_pipe[k] <= '0;
        end else begin
            tag_pipe[0] <= '{valid: xfer, ch: grant, last: xfer_last};
            for (int k = 1; k <= PIPE_LAT; k++) tag_pipe[k] <= tag_pipe[k-1];
        end
    end

    // Saturating ground count including the result arriving this cycle.
    always_comb begin
        cnt_next = gnd_cnt;
        if (tag_out.valid && seg_result_valid && seg_result && (gnd_cnt != '1)) begin
            cnt_next = gnd_cnt + CNT_W'(1);
        end
    end

    // Route results to their ring, flag tag/result mismatches, report packet totals.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid       <= 1'b0;
            res_ground      <= 1'b0;
            res_ch          <= '0;
            res_last        <= 1'b0;
            ring_done       <= 1'b0;
            ring_ch         <= '0;
            ring_ground_cnt <= '0;
            gnd_cnt         <= '0;
            err             <= 1'b0;
        end else begin
            res_valid  <= tag_out.valid && seg_result_valid;
            res_ground <= tag_out.valid && seg_result_valid && seg_result;
            res_ch     <= tag_out.ch;
            res_last   <= tag_out.valid && seg_result_valid && tag_out.last;
            ring_done  <= tag_out.valid && tag_out.last;
            if (tag_out.valid != seg_result_valid) err <= 1'b1;
            if (tag_out.valid && tag_out.last) begin
                ring_ch         <= tag_out.ch;
                ring_ground_cnt <= cnt_next;
                gnd_cnt         <= '0;
            end else begin
                gnd_cnt <= cnt_next;
            end
        end
    end

endmodule
